// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared widths, source indices and the writeback bundle type
package writeback_unit_pkg;

    localparam int REG_W   = 32;
    localparam int RADDR_W = 5;
    localparam int NREGS   = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_MUL = 2;

    typedef struct packed {
        logic               oper;
        logic [RADDR_W-1:0] regdest;
        logic               writereg;
        logic [REG_W-1:0]   wbvalue;
    } wb_bundle_t;

    // True when more than one bit of v is set
    function automatic logic multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/writeback_unit_reg_file.sv
// writeback_unit_reg_file: 32x32 architectural register file, r0 hard-wired to zero
module writeback_unit_reg_file
    import writeback_unit_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_we,
    input  logic [RADDR_W-1:0] i_waddr,
    input  logic [REG_W-1:0]   i_wdata,
    input  logic [RADDR_W-1:0] i_raddr_a,
    input  logic [RADDR_W-1:0] i_raddr_b,
    output logic [REG_W-1:0]   o_rdata_a,
    output logic [REG_W-1:0]   o_rdata_b
);

    logic [REG_W-1:0] r_mem [NREGS];

    // Clear everything on reset, otherwise one write per edge; r0 is never written
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: selects one FU result per cycle, commits it to the ARF and tracks pending registers
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int NSRC = 3
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               a3_wb_oper,
    input  logic [RADDR_W-1:0] a3_wb_regdest,
    input  logic               a3_wb_writereg,
    input  logic [REG_W-1:0]   a3_wb_wbvalue,
    input  logic               m_wb_oper,
    input  logic [RADDR_W-1:0] m_wb_regdest,
    input  logic               m_wb_writereg,
    input  logic [REG_W-1:0]   m_wb_wbvalue,
    input  logic               x_wb_oper,
    input  logic [RADDR_W-1:0] x_wb_regdest,
    input  logic               x_wb_writereg,
    input  logic [REG_W-1:0]   x_wb_wbvalue,
    input  logic               iss_wb_setpend,
    input  logic [RADDR_W-1:0] iss_wb_pendreg,
    input  logic [RADDR_W-1:0] iss_wb_rsa,
    input  logic [RADDR_W-1:0] iss_wb_rsb,
    output logic [REG_W-1:0]   wb_iss_rega,
    output logic [REG_W-1:0]   wb_iss_regb,
    output logic [NREGS-1:0]   wb_iss_pending,
    output logic               wb_rf_oper,
    output logic               wb_rf_writereg,
    output logic [RADDR_W-1:0] wb_rf_regdest,
    output logic [REG_W-1:0]   wb_rf_wbvalue,
    output logic               wb_collision
);

    wb_bundle_t         w_src [NSRC];
    wb_bundle_t         w_sel;
    logic [NSRC-1:0]    w_opers;
    logic [NREGS-1:0]   w_pend_next;
    logic               w_commit;
    logic [REG_W-1:0]   w_arf_a;
    logic [REG_W-1:0]   w_arf_b;

    wb_bundle_t         r_wb;
    logic               r_collision;
    logic [NREGS-1:0]   r_pending;

    // Pick the highest-priority presenting source; lower indices win
    always_comb begin
        w_src          = '{default: '0};
        w_src[SRC_ALU] = '{a3_wb_oper, a3_wb_regdest, a3_wb_writereg, a3_wb_wbvalue};
        w_src[SRC_MEM] = '{m_wb_oper,  m_wb_regdest,  m_wb_writereg,  m_wb_wbvalue};
        w_src[SRC_MUL] = '{x_wb_oper,  x_wb_regdest,  x_wb_writereg,  x_wb_wbvalue};
        w_sel   = '0;
        w_opers = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            w_opers[i] = w_src[i].oper;
            if (w_src[i].oper) w_sel = w_src[i];
        end
    end

    // Retire releases the register, but a same-edge issue set wins as it belongs to a newer instruction
    always_comb begin
        w_pend_next = r_pending;
        if (r_wb.oper) w_pend_next[r_wb.regdest] = 1'b0;
        if (iss_wb_setpend) w_pend_next[iss_wb_pendreg] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    // Stage register, sticky collision flag and scoreboard
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb        <= '0;
            r_collision <= 1'b0;
            r_pending   <= '0;
        end else begin
            r_wb        <= w_sel;
            r_collision <= r_collision | multi_hot(32'(w_opers));
            r_pending   <= w_pend_next;
        end
    end

    assign w_commit = r_wb.oper & r_wb.writereg & (r_wb.regdest != '0);

    writeback_unit_reg_file u_rf (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_we      (w_commit),
        .i_waddr   (r_wb.regdest),
        .i_wdata   (r_wb.wbvalue),
        .i_raddr_a (iss_wb_rsa),
        .i_raddr_b (iss_wb_rsb),
        .o_rdata_a (w_arf_a),
        .o_rdata_b (w_arf_b)
    );

    assign wb_iss_rega    = (iss_wb_rsa == '0) ? '0 :
                            (w_commit && r_wb.regdest == iss_wb_rsa) ? r_wb.wbvalue : w_arf_a;
    assign wb_iss_regb    = (iss_wb_rsb == '0) ? '0 :
                            (w_commit && r_wb.regdest == iss_wb_rsb) ? r_wb.wbvalue : w_arf_b;
    assign wb_iss_pending = r_pending;
    assign wb_rf_oper     = r_wb.oper;
    assign wb_rf_writereg = r_wb.writereg;
    assign wb_rf_regdest  = r_wb.regdest;
    assign wb_rf_wbvalue  = r_wb.wbvalue;
    assign wb_collision   = r_collision;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and randomized checks against a register-file-level reference model
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a3_wb_oper, m_wb_oper, x_wb_oper;
    logic [4:0]  a3_wb_regdest, m_wb_regdest, x_wb_regdest;
    logic        a3_wb_writereg, m_wb_writereg, x_wb_writereg;
    logic [31:0] a3_wb_wbvalue, m_wb_wbvalue, x_wb_wbvalue;
    logic        iss_wb_setpend;
    logic [4:0]  iss_wb_pendreg, iss_wb_rsa, iss_wb_rsb;
    logic [31:0] wb_iss_rega, wb_iss_regb, wb_iss_pending;
    logic        wb_rf_oper, wb_rf_writereg, wb_collision;
    logic [4:0]  wb_rf_regdest;
    logic [31:0] wb_rf_wbvalue;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_arf [32];
    logic [31:0] m_pend;
    logic        m_so, m_sw, m_coll;
    logic [4:0]  m_sd;
    logic [31:0] m_sv;

    writeback_unit dut (
        .clock          (clock),
        .reset          (reset),
        .a3_wb_oper     (a3_wb_oper),
        .a3_wb_regdest  (a3_wb_regdest),
        .a3_wb_writereg (a3_wb_writereg),
        .a3_wb_wbvalue  (a3_wb_wbvalue),
        .m_wb_oper      (m_wb_oper),
        .m_wb_regdest   (m_wb_regdest),
        .m_wb_writereg  (m_wb_writereg),
        .m_wb_wbvalue   (m_wb_wbvalue),
        .x_wb_oper      (x_wb_oper),
        .x_wb_regdest   (x_wb_regdest),
        .x_wb_writereg  (x_wb_writereg),
        .x_wb_wbvalue   (x_wb_wbvalue),
        .iss_wb_setpend (iss_wb_setpend),
        .iss_wb_pendreg (iss_wb_pendreg),
        .iss_wb_rsa     (iss_wb_rsa),
        .iss_wb_rsb     (iss_wb_rsb),
        .wb_iss_rega    (wb_iss_rega),
        .wb_iss_regb    (wb_iss_regb),
        .wb_iss_pending (wb_iss_pending),
        .wb_rf_oper     (wb_rf_oper),
        .wb_rf_writereg (wb_rf_writereg),
        .wb_rf_regdest  (wb_rf_regdest),
        .wb_rf_wbvalue  (wb_rf_wbvalue),
        .wb_collision   (wb_collision)
    );

    always #5 clock = ~clock;

    // Value issue should see for register r: whatever the ARF will hold once the in-flight result lands
    function automatic logic [31:0] peek(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (m_so && m_sw && m_sd == r) return m_sv;
        return m_arf[r];
    endfunction

    // Reference behaviour of one rising edge, from the currently driven inputs
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_arf[i] = 32'd0;
            m_pend = 32'd0;
            {m_so, m_sd, m_sw, m_sv} = '0;
            m_coll = 1'b0;
        end else begin
            if (m_so && m_sw && m_sd != 5'd0) m_arf[m_sd] = m_sv;
            if (m_so) m_pend[m_sd] = 1'b0;
            if (iss_wb_setpend && iss_wb_pendreg != 5'd0) m_pend[iss_wb_pendreg] = 1'b1;
            if (int'(a3_wb_oper) + int'(m_wb_oper) + int'(x_wb_oper) > 1) m_coll = 1'b1;
            if (a3_wb_oper)     {m_so, m_sd, m_sw, m_sv} = {1'b1, a3_wb_regdest, a3_wb_writereg, a3_wb_wbvalue};
            else if (m_wb_oper) {m_so, m_sd, m_sw, m_sv} = {1'b1, m_wb_regdest, m_wb_writereg, m_wb_wbvalue};
            else if (x_wb_oper) {m_so, m_sd, m_sw, m_sv} = {1'b1, x_wb_regdest, x_wb_writereg, x_wb_wbvalue};
            else                {m_so, m_sd, m_sw, m_sv} = '0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle();
        {a3_wb_oper, a3_wb_regdest, a3_wb_writereg, a3_wb_wbvalue} = '0;
        {m_wb_oper, m_wb_regdest, m_wb_writereg, m_wb_wbvalue} = '0;
        {x_wb_oper, x_wb_regdest, x_wb_writereg, x_wb_wbvalue} = '0;
        {iss_wb_setpend, iss_wb_pendreg, iss_wb_rsa, iss_wb_rsb} = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        a3_wb_oper = 1'b1; a3_wb_regdest = 5'd6; a3_wb_writereg = 1'b1; a3_wb_wbvalue = 32'h5555_AAAA;
        tick();
        tick();
        reset = 1'b0;
        idle();
        iss_wb_rsa = 5'd6; iss_wb_rsb = 5'd31;
        #1;
        checks++; if (wb_rf_oper !== 1'b0 || wb_rf_writereg !== 1'b0) begin errors++; $display("FAIL reset_ctrl oper=%b writereg=%b required 0 0", wb_rf_oper, wb_rf_writereg); end
        checks++; if (wb_rf_regdest !== 5'd0 || wb_rf_wbvalue !== 32'd0) begin errors++; $display("FAIL reset_data dest=%0d value=%h required 0 0", wb_rf_regdest, wb_rf_wbvalue); end
        checks++; if (wb_iss_pending !== 32'd0) begin errors++; $display("FAIL reset_pending got %h required 0", wb_iss_pending); end
        checks++; if (wb_collision !== 1'b0) begin errors++; $display("FAIL reset_collision got %b required 0", wb_collision); end
        checks++; if (wb_iss_rega !== 32'd0 || wb_iss_regb !== 32'd0) begin errors++; $display("FAIL reset_reads a=%h b=%h required 0 0", wb_iss_rega, wb_iss_regb); end
    endtask

    task automatic test_single_alu();
        idle();
        a3_wb_oper = 1'b1; a3_wb_regdest = 5'd5; a3_wb_writereg = 1'b1; a3_wb_wbvalue = 32'hDEAD_BEEF;
        tick();
        idle();
        iss_wb_rsa = 5'd5;
        #1;
        checks++; if (wb_rf_oper !== 1'b1 || wb_rf_regdest !== 5'd5) begin errors++; $display("FAIL alu_stage oper=%b dest=%0d required 1 5", wb_rf_oper, wb_rf_regdest); end
        checks++; if (wb_iss_rega !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_bypass got %h required deadbeef", wb_iss_rega); end
        tick();
        iss_wb_rsa = 5'd5;
        #1;
        checks++; if (wb_rf_oper !== 1'b0 || wb_iss_rega !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_commit oper=%b arf5=%h required 0 deadbeef", wb_rf_oper, wb_iss_rega); end
    endtask

    task automatic test_suppressed();
        idle();
        a3_wb_oper = 1'b1; a3_wb_regdest = 5'd7; a3_wb_writereg = 1'b1; a3_wb_wbvalue = 32'h77;
        tick();
        idle();
        tick();
        iss_wb_setpend = 1'b1; iss_wb_pendreg = 5'd7;
        tick();
        idle();
        #1;
        checks++; if (wb_iss_pending[7] !== 1'b1) begin errors++; $display("FAIL supp_set got %b required 1", wb_iss_pending[7]); end
        m_wb_oper = 1'b1; m_wb_regdest = 5'd7; m_wb_writereg = 1'b0; m_wb_wbvalue = 32'h1234;
        tick();
        idle();
        #1;
        checks++; if (wb_iss_pending[7] !== 1'b1) begin errors++; $display("FAIL supp_hold got %b required 1", wb_iss_pending[7]); end
        tick();
        iss_wb_rsa = 5'd7;
        #1;
        checks++; if (wb_iss_pending[7] !== 1'b0) begin errors++; $display("FAIL supp_clear got %b required 0", wb_iss_pending[7]); end
        checks++; if (wb_iss_rega !== 32'h77) begin errors++; $display("FAIL supp_arf got %h required 77", wb_iss_rega); end
    endtask

    task automatic test_race();
        idle();
        iss_wb_setpend = 1'b1; iss_wb_pendreg = 5'd9;
        tick();
        idle();
        x_wb_oper = 1'b1; x_wb_regdest = 5'd9; x_wb_writereg = 1'b1; x_wb_wbvalue = 32'h9999_0009;
        tick();
        idle();
        iss_wb_setpend = 1'b1; iss_wb_pendreg = 5'd9;
        tick();
        idle();
        iss_wb_rsb = 5'd9;
        #1;
        checks++; if (wb_iss_pending[9] !== 1'b1) begin errors++; $display("FAIL race_pending got %b required 1", wb_iss_pending[9]); end
        checks++; if (wb_iss_regb !== 32'h9999_0009) begin errors++; $display("FAIL race_arf got %h required 99990009", wb_iss_regb); end
    endtask

    task automatic test_r0();
        idle();
        a3_wb_oper = 1'b1; a3_wb_regdest = 5'd0; a3_wb_writereg = 1'b1; a3_wb_wbvalue = 32'hFFFF_FFFF;
        iss_wb_setpend = 1'b1; iss_wb_pendreg = 5'd0;
        tick();
        idle();
        #1;
        checks++; if (wb_iss_pending[0] !== 1'b0) begin errors++; $display("FAIL r0_pending got %b required 0", wb_iss_pending[0]); end
        checks++; if (wb_iss_rega !== 32'd0) begin errors++; $display("FAIL r0_bypass got %h required 0", wb_iss_rega); end
        tick();
        #1;
        checks++; if (wb_iss_regb !== 32'd0 || wb_iss_pending[0] !== 1'b0) begin errors++; $display("FAIL r0_arf got %h/%b required 0/0", wb_iss_regb, wb_iss_pending[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        idle();
        for (int i = 0; i < 4; i++) begin
            v = 32'hB2B0_0000 + 32'(i);
            a3_wb_oper = 1'b1; a3_wb_regdest = 5'd12; a3_wb_writereg = 1'b1; a3_wb_wbvalue = v;
            iss_wb_rsa = 5'd12;
            tick();
            #1;
            checks++; if (wb_iss_rega !== v) begin errors++; $display("FAIL b2b_%0d got %h required %h", i, wb_iss_rega, v); end
        end
        idle();
        tick();
        tick();
        iss_wb_rsa = 5'd12;
        #1;
        checks++; if (wb_iss_rega !== 32'hB2B0_0003) begin errors++; $display("FAIL b2b_final got %h required b2b00003", wb_iss_rega); end
    endtask

    task automatic test_random();
        int sel;
        logic [31:0] exp_a, exp_b;
        for (int n = 0; n < 400; n++) begin
            idle();
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: {a3_wb_oper, a3_wb_regdest, a3_wb_writereg, a3_wb_wbvalue} = {1'b1, 5'($urandom), $urandom_range(0, 3) != 0, 32'($urandom)};
                1: {m_wb_oper, m_wb_regdest, m_wb_writereg, m_wb_wbvalue} = {1'b1, 5'($urandom), $urandom_range(0, 3) != 0, 32'($urandom)};
                2: {x_wb_oper, x_wb_regdest, x_wb_writereg, x_wb_wbvalue} = {1'b1, 5'($urandom), $urandom_range(0, 3) != 0, 32'($urandom)};
                default: ;
            endcase
            iss_wb_setpend = 1'($urandom);
            iss_wb_pendreg = 5'($urandom);
            iss_wb_rsa = ($urandom_range(0, 1) == 0) ? m_sd : 5'($urandom);
            iss_wb_rsb = 5'($urandom);
            #1;
            exp_a = peek(iss_wb_rsa);
            exp_b = peek(iss_wb_rsb);
            checks++; if ({wb_rf_oper, wb_rf_regdest, wb_rf_writereg, wb_rf_wbvalue} !== {m_so, m_sd, m_sw, m_sv}) begin errors++; $display("FAIL rnd_stage_%0d got %b/%0d/%b/%h required %b/%0d/%b/%h", n, wb_rf_oper, wb_rf_regdest, wb_rf_writereg, wb_rf_wbvalue, m_so, m_sd, m_sw, m_sv); end
            checks++; if (wb_iss_pending !== m_pend) begin errors++; $display("FAIL rnd_pending_%0d got %h required %h", n, wb_iss_pending, m_pend); end
            checks++; if (wb_iss_rega !== exp_a || wb_iss_regb !== exp_b) begin errors++; $display("FAIL rnd_reads_%0d a[%0d]=%h b[%0d]=%h required %h %h", n, iss_wb_rsa, wb_iss_rega, iss_wb_rsb, wb_iss_regb, exp_a, exp_b); end
            checks++; if (wb_collision !== m_coll) begin errors++; $display("FAIL rnd_collision_%0d got %b required %b", n, wb_collision, m_coll); end
            tick();
        end
    endtask

    task automatic test_collision();
        logic [31:0] old4;
        idle();
        tick();
        old4 = peek(5'd4);
        a3_wb_oper = 1'b1; a3_wb_regdest = 5'd3; a3_wb_writereg = 1'b1; a3_wb_wbvalue = 32'h3333_3333;
        x_wb_oper  = 1'b1; x_wb_regdest  = 5'd4; x_wb_writereg  = 1'b1; x_wb_wbvalue  = 32'h4444_4444;
        tick();
        idle();
        #1;
        checks++; if (wb_collision !== 1'b1 || wb_rf_regdest !== 5'd3) begin errors++; $display("FAIL coll_flag flag=%b dest=%0d required 1 3", wb_collision, wb_rf_regdest); end
        tick();
        iss_wb_rsa = 5'd3; iss_wb_rsb = 5'd4;
        #1;
        checks++; if (wb_iss_rega !== 32'h3333_3333) begin errors++; $display("FAIL coll_winner got %h required 33333333", wb_iss_rega); end
        checks++; if (wb_iss_regb !== old4) begin errors++; $display("FAIL coll_loser got %h required %h", wb_iss_regb, old4); end
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            checks++; if (wb_collision !== 1'b1) begin errors++; $display("FAIL coll_sticky_%0d got %b required 1", i, wb_collision); end
        end
    endtask

    task automatic test_reset_mid();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 8; r < 12; r++) begin
            iss_wb_setpend = 1'b1; iss_wb_pendreg = 5'(r);
            tick();
        end
        idle();
        a3_wb_oper = 1'b1; a3_wb_regdest = 5'd13; a3_wb_writereg = 1'b1; a3_wb_wbvalue = 32'hC0FF_EE13;
        tick();
        idle();
        #1;
        checks++; if (wb_iss_pending !== 32'h0000_0F00 || wb_rf_oper !== 1'b1) begin errors++; $display("FAIL mid_setup pending=%h oper=%b required 00000f00 1", wb_iss_pending, wb_rf_oper); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if ({wb_rf_oper, wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_collision} !== '0) begin errors++; $display("FAIL mid_outputs got %b/%b/%0d/%h/%b required all 0", wb_rf_oper, wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_collision); end
        checks++; if (wb_iss_pending !== 32'd0) begin errors++; $display("FAIL mid_pending got %h required 0", wb_iss_pending); end
        for (int r = 0; r < 32; r++) begin
            iss_wb_rsa = 5'(r);
            #1;
            checks++; if (wb_iss_rega !== 32'd0) begin errors++; $display("FAIL mid_arf_%0d got %h required 0", r, wb_iss_rega); end
        end
        tick();
        iss_wb_rsb = 5'd13;
        #1;
        checks++; if (wb_iss_regb !== 32'd0) begin errors++; $display("FAIL mid_inflight got %h required 0", wb_iss_regb); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_alu();
        test_suppressed();
        test_race();
        test_r0();
        test_back_to_back();
        test_random();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
